// File: rtl/mc_seq_ctrl_pkg.sv
// Shared control encodings for the multi-cycle sequencer: next-PC selects,
// jump/branch types and the 3-bit sequencer state codes.
package mc_seq_ctrl_pkg;

    localparam logic [1:0] NPC_PLUS4    = 2'd0;
    localparam logic [1:0] NPC_BRANCH   = 2'd1;
    localparam logic [1:0] NPC_JUMP_IMM = 2'd2;
    localparam logic [1:0] NPC_JUMP_REG = 2'd3;

    localparam logic [1:0] JUMP_NONE = 2'd0;
    localparam logic [1:0] JUMP_IMM  = 2'd1;
    localparam logic [1:0] JUMP_REG  = 2'd2;

    localparam logic [1:0] BRANCH_NONE = 2'd0;
    localparam logic [1:0] BRANCH_BEQ  = 2'd1;
    localparam logic [1:0] BRANCH_BNE  = 2'd2;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

endpackage

// File: rtl/mc_seq_ctrl_retire_cnt.sv
// Retired-instruction counter: synchronous clear wins over increment,
// wraps modulo 2^Width.
module mc_seq_ctrl_retire_cnt #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + Width'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer: issues PC/IR/memory/GPR strobes from
// the current state and counts retired instructions.
module mc_seq_ctrl
    import mc_seq_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ID_NPCOp,
    input  logic [1:0]       ID_Jump,
    input  logic [1:0]       ID_Branch,
    input  logic             ID_Link,
    input  logic             ID_Load,
    input  logic             ID_Store,
    input  logic             ID_RegWr,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       NPCOp,
    output logic             RegWrite,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    state_t state_q, state_d;
    logic   retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        imem_req = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        NPCOp    = NPC_PLUS4;
        dmem_req = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;

        case (state_q)
            S_IF: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    IRWrite = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                PCWrite = 1'b1;
                NPCOp   = ID_NPCOp;
                // Jump outranks branch when a decoder flags both.
                if (ID_Jump != JUMP_NONE) begin
                    if (ID_Link) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end
                end else if (ID_Branch != BRANCH_NONE) begin
                    state_d = S_IF;
                    retire  = 1'b1;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                if (ID_Load || ID_Store) begin
                    state_d = S_MEM;
                end else if (ID_RegWr) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_IF;
                    retire  = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                MemWrite = ID_Store;
                if (dmem_ready) begin
                    if (ID_Store) begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                state_d  = S_IF;
                retire   = 1'b1;
            end
            default: state_d = S_IF;
        endcase

        // Reset cycle must not commit anything, even mid-stall.
        if (rst) begin
            retire   = 1'b0;
            imem_req = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            NPCOp    = NPC_PLUS4;
            dmem_req = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign state = state_q;

    mc_seq_ctrl_retire_cnt #(
        .Width (CNT_W)
    ) u_retire_cnt (
        .clk_i   (clk),
        .clr_i   (rst),
        .inc_i   (retire),
        .count_o (instret)
    );

endmodule

// File: doc/mc_seq_ctrl.md
Name: mc_seq_ctrl

Overview:
Multi-cycle instruction sequencer for the MIPS core. It steps each instruction through IF/ID/EX/MEM/WB. It issues the per-cycle write strobes for PC, IR, data memory and the register file, and handles ready handshakes with instruction and data memory. The PC is written exactly once per instruction, at the end of ID, using the NPCOp supplied by the ID-stage next-PC resolver.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ID_NPCOp  in  2  next-PC select from ID-stage resolver (NPC_PLUS4/NPC_BRANCH/NPC_JUMP_IMM/NPC_JUMP_REG)
ID_Jump  in  2  jump type of decoded instr (JUMP_NONE/JUMP_IMM/JUMP_REG)
ID_Branch  in  2  branch type (BRANCH_NONE/BRANCH_BEQ/BRANCH_BNE)
ID_Link  in  1  jump writes return address (jal/jalr)
ID_Load  in  1  instr is a load
ID_Store  in  1  instr is a store
ID_RegWr  in  1  instr writes GPR (R-type/I-type ALU, load, link)
imem_ready  in  1  instruction memory has data valid this cycle
dmem_ready  in  1  data memory access completes this cycle
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
MemWrite  out  1  store strobe (qualified by dmem_req)
IRWrite  out  1  latch instruction register
PCWrite  out  1  PC register load enable
NPCOp  out  2  registered-through NPC select driven to NPC mux
RegWrite  out  1  GPR write strobe
state  out  3  current state (debug)
instret  out  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset: state=S_IF, instret=0. All strobes are combinational from state and are therefore 0 in the reset cycle except imem_req, which is 1 once state=S_IF with rst low. NPCOp=NPC_PLUS4.
- States, 3-bit encoding: S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4. Codes 5-7 are illegal and go to S_IF next cycle with no strobes.
- S_IF: imem_req=1.
  - imem_ready=1: IRWrite=1, next S_ID.
  - Otherwise hold, no IRWrite.
- S_ID: always exactly one cycle. PCWrite=1, NPCOp=ID_NPCOp.
  - ID_Jump!=JUMP_NONE and ID_Link=1: next S_WB.
  - ID_Jump!=JUMP_NONE and ID_Link=0: next S_IF.
  - ID_Branch!=BRANCH_NONE: next S_IF (taken or not).
  - Otherwise: next S_EX.
  - Jump has priority over branch if both are flagged.
- S_EX: one cycle.
  - ID_Load or ID_Store: next S_MEM.
  - ID_RegWr: next S_WB.
  - Else: next S_IF (nop).
- S_MEM: dmem_req=1, MemWrite=ID_Store.
  - dmem_ready=0: hold, strobes stay asserted.
  - dmem_ready=1 and store: next S_IF.
  - dmem_ready=1 and load: next S_WB.
- S_WB: RegWrite=1 for one cycle, next S_IF.
- Decode inputs: must stay stable from S_ID through end of instruction. The datapath holds IR; the controller does not re-latch them.
- Retire event: the last cycle of an instruction, i.e. any transition into S_IF from S_ID/S_EX/S_MEM/S_WB. On a retire, instret increments by 1, wrapping modulo 2^CNT_W. A transition into S_IF caused by rst or an illegal state is not a retire.
- Ready outside request: imem_ready outside S_IF and dmem_ready outside S_MEM are ignored.
- NPCOp outside S_ID: NPC_PLUS4; PCWrite is 0.
- Reset mid-operation (any state, including an S_MEM stall): return to S_IF next edge. No PCWrite, RegWrite or MemWrite in the rst cycle; instret cleared.
- Latency, zero-wait memory:
  - Branch/j: 2 cycles.
  - jal/jalr: 3 cycles.
  - Store: 4 cycles.
  - ALU: 4 cycles.
  - Load: 5 cycles.

Decomposition:
- Add to shared ctrl_encode_def: state codes S_IF..S_WB and JUMP_NONE/BRANCH_NONE. NPC_* and JUMP_*/BRANCH_* constants are already defined there.
- Optional sub-module mc_retire_cnt: parameterised counter, increment and sync-clear.
- Next-state logic and output decode stay in one always block each.

Test Plan:
- rst high 3 cycles, then low with imem_ready=1 -> state=0 during rst, imem_req=1 first cycle after, instret=0, no PCWrite/RegWrite/MemWrite.
- addu, imem_ready=1, ID_RegWr=1 -> IF,ID(PCWrite=1, NPCOp=NPC_PLUS4),EX,WB(RegWrite=1), back to IF; instret 0->1 on IF entry; 4 cycles.
- beq with ID_NPCOp=NPC_BRANCH, then bne with ID_NPCOp=NPC_PLUS4 -> each exactly 2 cycles. PCWrite=1 in ID with matching NPCOp; no RegWrite; instret +2.
- jal (ID_Jump=JUMP_IMM, ID_Link=1, ID_NPCOp=NPC_JUMP_IMM) -> IF,ID,WB. RegWrite=1 in WB only; jr (ID_Link=0) -> IF,ID only.
- lw with dmem_ready low 3 cycles -> MEM held 4 cycles with dmem_req=1, MemWrite=0, then WB RegWrite=1; total 8 cycles. sw same stall -> MemWrite=1 throughout MEM, no WB.
- rst asserted during MEM stall -> next edge state=S_IF, instret=0, no MemWrite in rst cycle. Also force state=6 -> S_IF next cycle, instret unchanged.
